riscv_ex_div: RTL

Iterative radix-2 restoring divider for the RV64M divide/remainder instructions. The EX stage issues requests to it over a valid/ready handshake, and it hands a registered result back to EX/WB over a second valid/ready handshake. It is the multi-cycle responder that sits beside the single-cycle EX ALU; EX stalls while a request is outstanding.

---
 rtl/riscv_ex_div_pkg.sv | 30 +++
 rtl/riscv_div_abs_ext.sv | 24 ++
 rtl/riscv_ex_div.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_ex_div_pkg.sv
// Shared op codes, FSM state type and op-decode helpers for the RV64M divider.
package riscv_ex_div_pkg;

    localparam int unsigned DIV_OPT_W = 3;

    // bit0 = unsigned, bit1 = remainder, bit2 = 32-bit W variant
    localparam logic [DIV_OPT_W-1:0] DIV_DIV   = 3'd0;
    localparam logic [DIV_OPT_W-1:0] DIV_DIVU  = 3'd1;
    localparam logic [DIV_OPT_W-1:0] DIV_REM   = 3'd2;
    localparam logic [DIV_OPT_W-1:0] DIV_REMU  = 3'd3;
    localparam logic [DIV_OPT_W-1:0] DIV_DIVW  = 3'd4;
    localparam logic [DIV_OPT_W-1:0] DIV_DIVUW = 3'd5;
    localparam logic [DIV_OPT_W-1:0] DIV_REMW  = 3'd6;
    localparam logic [DIV_OPT_W-1:0] DIV_REMUW = 3'd7;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} div_state_e;

    function automatic logic op_is_signed(input logic [DIV_OPT_W-1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [DIV_OPT_W-1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_w(input logic [DIV_OPT_W-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/riscv_div_abs_ext.sv
// Operand preparation: optional W-extension of the low half, sign flag and magnitude.
module riscv_div_abs_ext #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  is_w,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] ext,
    output logic [DATA_WIDTH-1:0] mag,
    output logic                  neg
);
    localparam int unsigned HW = DATA_WIDTH / 2;

    always_comb begin
        if (is_w) begin
            ext = {{HW{is_signed & data[HW-1]}}, data[HW-1:0]};
        end else begin
            ext = data;
        end
        neg = is_signed & ext[DATA_WIDTH-1];
        mag = neg ? -ext : ext;
    end

endmodule

// File: rtl/riscv_ex_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM ops, one quotient bit per cycle.
// Optional RISCV_DIV_EARLY_OUT_EN retires divide-by-zero and |a| < |b| straight from IDLE.
module riscv_ex_div
    import riscv_ex_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned DIV_OPT_WIDTH = DIV_OPT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     div_flush,
    input  logic                     div_valid,
    output logic                     div_ready,
    input  logic [DIV_OPT_WIDTH-1:0] div_opt,
    input  logic [DATA_WIDTH-1:0]    div_a_data,
    input  logic [DATA_WIDTH-1:0]    div_b_data,
    output logic                     div_out_valid,
    input  logic                     div_out_ready,
    output logic [DATA_WIDTH-1:0]    div_out_data
);
    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    div_state_e            state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] dvd_q, rem_q, b_mag_q;
    logic                  is_w_q, is_rem_q, quo_neg_q, rem_neg_q;

    logic                  in_w, in_rem, in_signed, in_b_zero, in_quo_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, b_ext, unused_a_ext;
    logic                  a_neg, b_neg;

    assign in_w       = op_is_w(div_opt);
    assign in_rem     = op_is_rem(div_opt);
    assign in_signed  = op_is_signed(div_opt);
    assign in_b_zero  = (b_ext == '0);
    assign in_quo_neg = (a_neg ^ b_neg) & ~in_b_zero;

    riscv_div_abs_ext #(.DATA_WIDTH(DATA_WIDTH)) u_abs_a (
        .data      (div_a_data),
        .is_w      (in_w),
        .is_signed (in_signed),
        .ext       (unused_a_ext),
        .mag       (a_mag),
        .neg       (a_neg)
    );

    riscv_div_abs_ext #(.DATA_WIDTH(DATA_WIDTH)) u_abs_b (
        .data      (div_b_data),
        .is_w      (in_w),
        .is_signed (in_signed),
        .ext       (b_ext),
        .mag       (b_mag),
        .neg       (b_neg)
    );

    // One restoring step: shift in the next dividend bit, try subtracting |b|.
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH+1:0] diff;
    logic                  q_bit, unused_diff_bit;
    logic [DATA_WIDTH-1:0] rem_nxt, dvd_nxt;

    assign trial           = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign diff            = {1'b0, trial} - {2'b00, b_mag_q};
    assign q_bit           = ~diff[DATA_WIDTH+1];
    assign unused_diff_bit = diff[DATA_WIDTH];
    assign rem_nxt         = q_bit ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    assign dvd_nxt         = {dvd_q[DATA_WIDTH-2:0], q_bit};

    function automatic logic [DATA_WIDTH-1:0] fix_up(input logic [DATA_WIDTH-1:0] q,
                                                     input logic [DATA_WIDTH-1:0] r,
                                                     input logic want_rem, input logic nq,
                                                     input logic nr, input logic w);
        logic [DATA_WIDTH-1:0] res;
        if (want_rem) res = nr ? -r : r;
        else          res = nq ? -q : q;
        if (w) res = {{HW{res[HW-1]}}, res[HW-1:0]};
        return res;
    endfunction

    logic                  early;
    logic [DATA_WIDTH-1:0] early_res;
`ifdef RISCV_DIV_EARLY_OUT_EN
    assign early     = in_b_zero | (a_mag < b_mag);
    assign early_res = fix_up({DATA_WIDTH{in_b_zero}}, a_mag, in_rem, in_quo_neg, a_neg, in_w);
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    assign div_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            dvd_q         <= '0;
            rem_q         <= '0;
            b_mag_q       <= '0;
            is_w_q        <= 1'b0;
            is_rem_q      <= 1'b0;
            quo_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            div_out_valid <= 1'b0;
            div_out_data  <= '0;
        end else if (div_flush) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            div_out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (div_valid) begin
                        is_w_q    <= in_w;
                        is_rem_q  <= in_rem;
                        quo_neg_q <= in_quo_neg;
                        rem_neg_q <= a_neg;
                        b_mag_q   <= b_mag;
                        rem_q     <= '0;
                        // W ops start with the 32-bit magnitude left-aligned
                        dvd_q     <= in_w ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                        if (early) begin
                            state_q       <= StDone;
                            div_out_valid <= 1'b1;
                            div_out_data  <= early_res;
                        end else begin
                            state_q <= StCalc;
                            cnt_q   <= in_w ? CW'(HW - 1) : CW'(DATA_WIDTH - 1);
                        end
                    end
                end
                StCalc: begin
                    dvd_q <= dvd_nxt;
                    rem_q <= rem_nxt;
                    if (cnt_q == '0) begin
                        state_q       <= StDone;
                        div_out_valid <= 1'b1;
                        div_out_data  <= fix_up(dvd_nxt, rem_nxt, is_rem_q, quo_neg_q,
                                                rem_neg_q, is_w_q);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StDone: begin
                    if (div_out_ready) begin
                        state_q       <= StIdle;
                        div_out_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
